apb_master_bridge29: RTL and testbench

//  APB requester: the initiating end of the bus that apb_slave_if29 samples.

---
 rtl/apb_bridge_pkg29.sv | 16 +
 rtl/apb_slave_decode29.sv | 20 ++
 rtl/apb_master_bridge29.sv | 173 +++++++++++++++++
 tb/tb_apb_master_bridge29.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_bridge_pkg29.sv
// Shared types and helpers for the APB requester bridge and its address decoder.
package apb_bridge_pkg29;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    // Response status flags; read data is kept beside them at the bridge's own width.
    typedef struct packed {
        logic slverr;
        logic timeout;
    } rsp_t;

    function automatic int selw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_slave_decode29.sv
// Slave-index field -> one-hot psel pattern; an index with no slave behind it flags a decode error.
module apb_slave_decode29 #(
    parameter int NUM_SLAVES29 = 4,
    parameter int SELW         = 2
) (
    input  logic [SELW-1:0]         addr_field,
    output logic [NUM_SLAVES29-1:0] sel,
    output logic                    decode_err
);

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_SLAVES29; i++) begin
            sel[i] = (addr_field == SELW'(i));
        end
    end

    assign decode_err = ~|sel;

endmodule

// File: rtl/apb_master_bridge29.sv
// APB requester: one valid/ready request at a time is turned into a SETUP/ACCESS bus cycle,
// with a registered valid/ready response and an optional wait-state timeout.
module apb_master_bridge29
    import apb_bridge_pkg29::*;
#(
    parameter int PADDR_WIDTH29  = 32,
    parameter int PWDATA_WIDTH29 = 32,
    parameter int PRDATA_WIDTH29 = 32,
    parameter int NUM_SLAVES29   = 4,
    parameter int SEL_LSB29      = 12,
    parameter int TIMEOUT29      = 256
) (
    input  logic                                   pclock29,
    input  logic                                   preset29,
    input  logic                                   req_valid29,
    output logic                                   req_ready29,
    input  logic [PADDR_WIDTH29-1:0]               req_addr29,
    input  logic                                   req_write29,
    input  logic [PWDATA_WIDTH29-1:0]              req_wdata29,
    output logic                                   rsp_valid29,
    input  logic                                   rsp_ready29,
    output logic [PRDATA_WIDTH29-1:0]              rsp_rdata29,
    output logic                                   rsp_slverr29,
    output logic                                   rsp_timeout29,
    output logic [PADDR_WIDTH29-1:0]               paddr29,
    output logic                                   prwd29,
    output logic [PWDATA_WIDTH29-1:0]              pwdata29,
    output logic [NUM_SLAVES29-1:0]                psel29,
    output logic                                   penable29,
    input  logic [NUM_SLAVES29*PRDATA_WIDTH29-1:0] prdata29,
    input  logic [NUM_SLAVES29-1:0]                pready29,
    input  logic [NUM_SLAVES29-1:0]                pslverr29
);

    localparam int SELW = selw(NUM_SLAVES29);
    localparam int CNTW = (TIMEOUT29 < 2) ? 1 : $clog2(TIMEOUT29 + 1);
    localparam logic [CNTW-1:0] TMO = CNTW'(TIMEOUT29);

    state_t                      state, state_nxt;
    logic [CNTW-1:0]             cnt, cnt_nxt, cnt_inc;
    logic [NUM_SLAVES29-1:0]     psel_q, psel_nxt, dec_sel;
    logic                        penable_q, penable_nxt;
    logic [PADDR_WIDTH29-1:0]    paddr_q, paddr_nxt;
    logic                        prwd_q, prwd_nxt;
    logic [PWDATA_WIDTH29-1:0]   pwdata_q, pwdata_nxt;
    logic                        rsp_valid_q, rsp_valid_nxt;
    logic [PRDATA_WIDTH29-1:0]   rdata_q, rdata_nxt, sel_rdata;
    rsp_t                        flags_q, flags_nxt;
    logic                        dec_err, sel_ready, sel_err;

    apb_slave_decode29 #(
        .NUM_SLAVES29 (NUM_SLAVES29),
        .SELW         (SELW)
    ) u_decode (
        .addr_field (req_addr29[SEL_LSB29 +: SELW]),
        .sel        (dec_sel),
        .decode_err (dec_err)
    );

    // The registered one-hot psel doubles as the mux select, so unselected slaves never leak in.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES29; i++) begin
            if (psel_q[i]) sel_rdata = sel_rdata | prdata29[i*PRDATA_WIDTH29 +: PRDATA_WIDTH29];
        end
    end

    assign sel_ready   = |(pready29 & psel_q);
    assign sel_err     = |(pslverr29 & psel_q);
    assign req_ready29 = (state == IDLE) && !preset29;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        cnt_inc       = cnt + 1'b1;
        psel_nxt      = psel_q;
        penable_nxt   = penable_q;
        paddr_nxt     = paddr_q;
        prwd_nxt      = prwd_q;
        pwdata_nxt    = pwdata_q;
        rsp_valid_nxt = rsp_valid_q;
        rdata_nxt     = rdata_q;
        flags_nxt     = flags_q;
        case (state)
            IDLE: begin
                if (req_valid29 && req_ready29) begin
                    if (dec_err) begin
                        state_nxt     = RESP;
                        rsp_valid_nxt = 1'b1;
                        rdata_nxt     = '0;
                        flags_nxt     = '{slverr: 1'b1, timeout: 1'b0};
                    end else begin
                        state_nxt   = SETUP;
                        psel_nxt    = dec_sel;
                        penable_nxt = 1'b0;
                        paddr_nxt   = req_addr29;
                        prwd_nxt    = req_write29;
                        pwdata_nxt  = req_wdata29;
                    end
                end
            end
            SETUP: begin
                state_nxt   = ACCESS;
                penable_nxt = 1'b1;
                cnt_nxt     = '0;
            end
            ACCESS: begin
                if (sel_ready) begin
                    state_nxt     = RESP;
                    psel_nxt      = '0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rdata_nxt     = prwd_q ? '0 : sel_rdata;
                    flags_nxt     = '{slverr: sel_err, timeout: 1'b0};
                end else begin
                    cnt_nxt = cnt_inc;
                    if (TIMEOUT29 != 0 && cnt_inc == TMO) begin
                        state_nxt     = RESP;
                        psel_nxt      = '0;
                        penable_nxt   = 1'b0;
                        rsp_valid_nxt = 1'b1;
                        rdata_nxt     = '0;
                        flags_nxt     = '{slverr: 1'b1, timeout: 1'b1};
                    end
                end
            end
            RESP: begin
                if (rsp_ready29) begin
                    state_nxt     = IDLE;
                    rsp_valid_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclock29) begin
        if (preset29) begin
            state       <= IDLE;
            cnt         <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            prwd_q      <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            flags_q     <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            psel_q      <= psel_nxt;
            penable_q   <= penable_nxt;
            paddr_q     <= paddr_nxt;
            prwd_q      <= prwd_nxt;
            pwdata_q    <= pwdata_nxt;
            rsp_valid_q <= rsp_valid_nxt;
            rdata_q     <= rdata_nxt;
            flags_q     <= flags_nxt;
        end
    end

    assign psel29        = psel_q;
    assign penable29     = penable_q;
    assign paddr29       = paddr_q;
    assign prwd29        = prwd_q;
    assign pwdata29      = pwdata_q;
    assign rsp_valid29   = rsp_valid_q;
    assign rsp_rdata29   = rdata_q;
    assign rsp_slverr29  = flags_q.slverr;
    assign rsp_timeout29 = flags_q.timeout;

endmodule

// File: tb/tb_apb_master_bridge29.sv
// Bench for apb_master_bridge29: directed vector table, reset-abort sequence and random traffic
// checked against a transaction-level model of the bridge.
module tb_apb_master_bridge29;

    localparam int NS  = 5;
    localparam int SL  = 12;
    localparam int TMO = 8;

    logic            clk = 1'b0;
    logic            preset29;
    logic            req_valid29, req_ready29, req_write29;
    logic [31:0]     req_addr29, req_wdata29;
    logic            rsp_valid29, rsp_ready29, rsp_slverr29, rsp_timeout29;
    logic [31:0]     rsp_rdata29, paddr29, pwdata29;
    logic            prwd29, penable29;
    logic [NS-1:0]   psel29, pready29, pslverr29;
    logic [NS*32-1:0] prdata29;

    int errors = 0;
    int checks = 0;
    logic [31:0] last_addr = '0, last_wd = '0;
    logic        last_wr = 1'b0;

    apb_master_bridge29 #(
        .PADDR_WIDTH29 (32), .PWDATA_WIDTH29 (32), .PRDATA_WIDTH29 (32),
        .NUM_SLAVES29 (NS), .SEL_LSB29 (SL), .TIMEOUT29 (TMO)
    ) dut (
        .pclock29 (clk), .preset29 (preset29),
        .req_valid29 (req_valid29), .req_ready29 (req_ready29), .req_addr29 (req_addr29),
        .req_write29 (req_write29), .req_wdata29 (req_wdata29),
        .rsp_valid29 (rsp_valid29), .rsp_ready29 (rsp_ready29), .rsp_rdata29 (rsp_rdata29),
        .rsp_slverr29 (rsp_slverr29), .rsp_timeout29 (rsp_timeout29),
        .paddr29 (paddr29), .prwd29 (prwd29), .pwdata29 (pwdata29), .psel29 (psel29),
        .penable29 (penable29), .prdata29 (prdata29), .pready29 (pready29), .pslverr29 (pslverr29)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level expectation: what response a request earns and how long ACCESS lasts.
    function automatic void model(input logic [31:0] addr, input logic wr, input int waits,
                                  input logic serr, input logic [31:0] srd,
                                  output logic dec, output int nacc, output logic [31:0] rd,
                                  output logic err, output logic tmo);
        int idx;
        idx = int'(addr[SL +: 3]);
        dec = (idx >= NS);
        if (dec) begin
            nacc = 0; rd = '0; err = 1'b1; tmo = 1'b0;
        end else if (waits >= TMO) begin
            nacc = TMO; rd = '0; err = 1'b1; tmo = 1'b1;
        end else begin
            nacc = waits + 1; rd = wr ? 32'h0 : srd; err = serr; tmo = 1'b0;
        end
    endfunction

    // Every slave babbles randomly; only the selected one follows the scripted answer.
    task automatic drive_slaves(input int sidx, input logic rdy, input logic serr, input logic [31:0] srd);
        for (int i = 0; i < NS; i++) begin
            pready29[i]           = 1'($urandom_range(0, 1));
            pslverr29[i]          = 1'($urandom_range(0, 1));
            prdata29[i*32 +: 32]  = $urandom;
        end
        if (sidx >= 0 && sidx < NS) begin
            pready29[sidx] = rdy;
            if (rdy) begin
                pslverr29[sidx]         = serr;
                prdata29[sidx*32 +: 32] = srd;
            end
        end
    endtask

    task automatic chk_bus(input string ph, input logic [NS-1:0] esel, input logic en,
                           input logic [31:0] a, input logic w, input logic [31:0] wd);
        chk({ph, "_psel"}, 64'(psel29), 64'(esel));
        chk({ph, "_penable"}, 64'(penable29), 64'(en));
        chk({ph, "_paddr"}, 64'(paddr29), 64'(a));
        chk({ph, "_prwd"}, 64'(prwd29), 64'(w));
        chk({ph, "_pwdata"}, 64'(pwdata29), 64'(wd));
        chk({ph, "_rsp_valid"}, 64'(rsp_valid29), 64'(0));
        chk({ph, "_req_ready"}, 64'(req_ready29), 64'(0));
    endtask

    task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                           input int waits, input logic serr, input logic [31:0] srd, input int hold,
                           input logic [31:0] e_rd, input logic e_err, input logic e_tmo);
        logic dec, m_err, m_tmo;
        int nacc, idx;
        logic [31:0] m_rd;
        logic [NS-1:0] esel;
        model(addr, wr, waits, serr, srd, dec, nacc, m_rd, m_err, m_tmo);
        idx  = int'(addr[SL +: 3]);
        esel = '0;
        if (!dec) esel[idx] = 1'b1;
        chk("idle_req_ready", 64'(req_ready29), 64'(1));
        chk("idle_rsp_valid", 64'(rsp_valid29), 64'(0));
        chk("idle_psel", 64'(psel29), 64'(0));
        req_valid29 = 1'b1; req_addr29 = addr; req_write29 = wr; req_wdata29 = wd;
        rsp_ready29 = 1'($urandom_range(0, 1));
        drive_slaves(-1, 1'b0, 1'b0, 32'h0);
        @(posedge clk); @(negedge clk);
        if (!dec) begin
            chk_bus("setup", esel, 1'b0, addr, wr, wd);
            req_valid29 = 1'($urandom_range(0, 1)); req_addr29 = $urandom; req_wdata29 = $urandom;
            drive_slaves(idx, 1'($urandom_range(0, 1)), 1'b1, $urandom);
            @(posedge clk); @(negedge clk);
            for (int k = 0; k < nacc; k++) begin
                chk_bus("access", esel, 1'b1, addr, wr, wd);
                req_valid29 = 1'($urandom_range(0, 1)); req_addr29 = $urandom;
                rsp_ready29 = 1'($urandom_range(0, 1));
                drive_slaves(idx, (k == waits), serr, srd);
                @(posedge clk); @(negedge clk);
            end
            last_addr = addr; last_wr = wr; last_wd = wd;
        end
        for (int h = 0; h <= hold; h++) begin
            chk("rsp_valid", 64'(rsp_valid29), 64'(1));
            chk("rsp_rdata", 64'(rsp_rdata29), 64'(e_rd));
            chk("rsp_slverr", 64'(rsp_slverr29), 64'(e_err));
            chk("rsp_timeout", 64'(rsp_timeout29), 64'(e_tmo));
            chk("rsp_psel", 64'(psel29), 64'(0));
            chk("rsp_penable", 64'(penable29), 64'(0));
            chk("rsp_req_ready", 64'(req_ready29), 64'(0));
            chk("rsp_paddr_kept", 64'(paddr29), 64'(last_addr));
            chk("rsp_prwd_kept", 64'(prwd29), 64'(last_wr));
            chk("rsp_pwdata_kept", 64'(pwdata29), 64'(last_wd));
            rsp_ready29 = (h == hold);
            req_valid29 = (h == hold) ? 1'b0 : 1'($urandom_range(0, 1));
            drive_slaves(-1, 1'b0, 1'b0, 32'h0);
            @(posedge clk); @(negedge clk);
        end
        chk("done_rsp_valid", 64'(rsp_valid29), 64'(0));
        chk("done_req_ready", 64'(req_ready29), 64'(1));
        chk("done_paddr_kept", 64'(paddr29), 64'(last_addr));
        rsp_ready29 = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wd;
        int          waits;
        logic        serr;
        logic [31:0] srd;
        int          hold;
        logic [31:0] e_rd;
        logic        e_err;
        logic        e_tmo;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic dec, m_err, m_tmo;
        int nacc, waits, hold;
        logic [31:0] m_rd, addr, wd, srd;
        logic wr, serr;

        vecs[0] = '{32'h0000_1004, 1'b1, 32'hA5A5_0001, 0, 1'b0, 32'h1111_2222, 0, 32'h0, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_3000, 1'b0, 32'h0,        5, 1'b0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b0, 1'b0};
        vecs[2] = '{32'h0000_5000, 1'b0, 32'h0,        0, 1'b0, 32'h0,         0, 32'h0, 1'b1, 1'b0};
        vecs[3] = '{32'h0000_0010, 1'b0, 32'h0,       20, 1'b0, 32'h3333_4444, 1, 32'h0, 1'b1, 1'b1};
        vecs[4] = '{32'h0000_2008, 1'b1, 32'h0BAD_F00D, 0, 1'b1, 32'h5555_6666, 10, 32'h0, 1'b1, 1'b0};
        vecs[5] = '{32'h0000_4FFC, 1'b0, 32'h0,        7, 1'b0, 32'h1234_5678, 2, 32'h1234_5678, 1'b0, 1'b0};
        vecs[6] = '{32'h0000_7000, 1'b1, 32'hFFFF_FFFF, 0, 1'b0, 32'h0,        0, 32'h0, 1'b1, 1'b0};
        vecs[7] = '{32'h0000_0000, 1'b0, 32'h0,        8, 1'b0, 32'h7777_8888, 0, 32'h0, 1'b1, 1'b1};

        preset29 = 1'b1; req_valid29 = 1'b0; req_addr29 = '0; req_write29 = 1'b0; req_wdata29 = '0;
        rsp_ready29 = 1'b0;
        drive_slaves(-1, 1'b0, 1'b0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 64'(req_ready29), 64'(0));
        chk("reset_rsp_valid", 64'(rsp_valid29), 64'(0));
        chk("reset_psel", 64'(psel29), 64'(0));
        chk("reset_penable", 64'(penable29), 64'(0));
        chk("reset_paddr", 64'(paddr29), 64'(0));
        chk("reset_rdata", 64'(rsp_rdata29), 64'(0));
        chk("reset_slverr", 64'(rsp_slverr29), 64'(0));
        preset29 = 1'b0;
        @(posedge clk); @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            do_xfer(vecs[v].addr, vecs[v].wr, vecs[v].wd, vecs[v].waits, vecs[v].serr, vecs[v].srd,
                    vecs[v].hold, vecs[v].e_rd, vecs[v].e_err, vecs[v].e_tmo);
        end

        // Reset arriving during ACCESS must drop the bus and discard the transfer.
        req_valid29 = 1'b1; req_addr29 = 32'h0000_2100; req_write29 = 1'b0; req_wdata29 = '0;
        @(posedge clk); @(negedge clk);
        req_valid29 = 1'b0;
        drive_slaves(2, 1'b0, 1'b0, 32'h0);
        @(posedge clk); @(negedge clk);
        chk("rst_seq_access_psel", 64'(psel29), 64'(5'b00100));
        chk("rst_seq_access_penable", 64'(penable29), 64'(1));
        drive_slaves(2, 1'b0, 1'b0, 32'h0);
        preset29 = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rst_seq_psel", 64'(psel29), 64'(0));
        chk("rst_seq_penable", 64'(penable29), 64'(0));
        chk("rst_seq_rsp_valid", 64'(rsp_valid29), 64'(0));
        chk("rst_seq_req_ready", 64'(req_ready29), 64'(0));
        chk("rst_seq_paddr", 64'(paddr29), 64'(0));
        preset29 = 1'b0;
        drive_slaves(2, 1'b1, 1'b1, 32'hABCD_0000);
        @(posedge clk); @(negedge clk);
        chk("rst_seq_after_rsp_valid", 64'(rsp_valid29), 64'(0));
        chk("rst_seq_after_psel", 64'(psel29), 64'(0));
        last_addr = '0; last_wr = 1'b0; last_wd = '0;
        do_xfer(32'h0000_1040, 1'b0, 32'h0, 2, 1'b0, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 1'b0, 1'b0);

        for (int r = 0; r < 40; r++) begin
            addr = $urandom;
            addr[SL +: 3] = 3'($urandom_range(0, 7));
            wr    = 1'($urandom_range(0, 1));
            wd    = $urandom;
            waits = $urandom_range(0, 10);
            serr  = 1'($urandom_range(0, 1));
            srd   = $urandom;
            hold  = $urandom_range(0, 3);
            model(addr, wr, waits, serr, srd, dec, nacc, m_rd, m_err, m_tmo);
            do_xfer(addr, wr, wd, waits, serr, srd, hold, m_rd, m_err, m_tmo);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
